key_conditioner: RTL and testbench



---
 rtl/key_cond_pkg.sv | 12 +
 rtl/key_debounce_channel.sv | 83 ++++++++
 rtl/key_conditioner.sv | 29 ++
 tb/tb_key_conditioner.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// key_cond_pkg: debounce FSM state encoding and counter width helper shared by the key conditioner
package key_cond_pkg;
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_e;
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one key; clk_50M/rst(async low), key_n raw pin in, registered key_level/key_press/key_release/key_hold out
module key_debounce_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_hold
);
  localparam int W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam logic [W-1:0] DEB_LAST  = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] HOLD_LAST = W'(LONG_CYCLES == 0 ? 0 : LONG_CYCLES - 1);
  localparam logic [W-1:0] HOLD_MAX  = W'(LONG_CYCLES);
  localparam logic HOLD_EN = LONG_CYCLES != 0;
  logic [1:0] sync;
  logic pressed_s;
  key_state_e state, state_d;
  logic [W-1:0] cnt, cnt_d, hold_cnt, hold_d;
  logic level_d, press_d, release_d, hold_p_d;
  assign pressed_s = ~sync[1];
  always_ff @(posedge clk_50M or negedge rst)
    if (!rst) begin
      sync        <= 2'b11;
      state       <= RELEASED;
      cnt         <= '0;
      hold_cnt    <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_hold    <= 1'b0;
    end else begin
      sync        <= {sync[0], key_n};
      state       <= state_d;
      cnt         <= cnt_d;
      hold_cnt    <= hold_d;
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
      key_hold    <= hold_p_d;
    end
  // hold_cnt saturates at LONG_CYCLES so the hold pulse fires once per press
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    hold_d    = hold_cnt;
    level_d   = key_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_p_d  = 1'b0;
    case (state)
      RELEASED: begin
        state_d = pressed_s ? PRESS_CHK : RELEASED;
        cnt_d   = '0;
      end
      PRESS_CHK: begin
        state_d = !pressed_s ? RELEASED : cnt == DEB_LAST ? PRESSED : PRESS_CHK;
        cnt_d   = cnt + 1'b1;
        level_d = pressed_s && cnt == DEB_LAST;
        press_d = pressed_s && cnt == DEB_LAST;
      end
      PRESSED: begin
        hold_d   = hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + 1'b1;
        hold_p_d = HOLD_EN && hold_cnt == HOLD_LAST;
        state_d  = pressed_s ? PRESSED : RELEASE_CHK;
        cnt_d    = '0;
      end
      RELEASE_CHK: begin
        state_d   = pressed_s ? PRESSED : cnt == DEB_LAST ? RELEASED : RELEASE_CHK;
        cnt_d     = cnt + 1'b1;
        level_d   = pressed_s || cnt != DEB_LAST;
        release_d = !pressed_s && cnt == DEB_LAST;
        hold_d    = release_d ? '0 : hold_cnt;
      end
      default: state_d = RELEASED;
    endcase
  end
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: NUM_KEYS debounced keys; clk_50M/rst(async low), key_n raw pins in, key_level/key_press/key_release/key_hold per key out
module key_conditioner #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic                clk_50M,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_hold
);
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_chan (
      .clk_50M    (clk_50M),
      .rst        (rst),
      .key_n      (key_n[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_hold   (key_hold[i])
    );
  end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of debounce latency, bounce rejection, long hold, simultaneity and reset
module tb_key_conditioner;
  logic clk_50M = 1'b0;
  logic rst = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic [2:0] key_level, key_press, key_release, key_hold;
  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int n_press[3], n_rel[3], n_hold[3], e_press[3], e_hold[3];
  logic pat[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  key_conditioner #(
    .NUM_KEYS       (3),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10)
  ) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_hold   (key_hold)
  );
  always #10 clk_50M = ~clk_50M;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clear_stats();
    for (int k = 0; k < 3; k++) begin
      n_press[k] = 0;
      n_rel[k]   = 0;
      n_hold[k]  = 0;
      e_press[k] = -1;
      e_hold[k]  = -1;
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50M);
      #1;
      edge_n++;
      for (int k = 0; k < 3; k++) begin
        if (key_press[k]) begin
          n_press[k]++;
          e_press[k] = edge_n;
        end
        if (key_release[k]) n_rel[k]++;
        if (key_hold[k]) begin
          n_hold[k]++;
          e_hold[k] = edge_n;
        end
      end
    end
  endtask
  initial begin
    clear_stats();
    step(3);
    check("reset_outputs", {key_level, key_press, key_release, key_hold}, 12'h000);
    rst = 1'b1;
    // 1: clean press and release on key 0
    clear_stats();
    key_n = 3'b110;
    step(6);
    check("t1_e6_press", key_press, 3'b000);
    check("t1_e6_level", key_level, 3'b000);
    step(1);
    check("t1_e7_press", key_press, 3'b001);
    check("t1_e7_level", key_level, 3'b001);
    step(1);
    check("t1_press_width", key_press, 3'b000);
    step(22);
    check("t1_hold_count", n_hold[0], 1);
    check("t1_hold_latency", e_hold[0] - e_press[0], 10);
    key_n = 3'b111;
    step(6);
    check("t1_rel_early", n_rel[0], 0);
    check("t1_rel_e6_level", key_level, 3'b001);
    step(1);
    check("t1_release", key_release, 3'b001);
    check("t1_rel_level", key_level, 3'b000);
    step(1);
    check("t1_release_width", key_release, 3'b000);
    // 2: bounce on key 1
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      key_n[1] = pat[i];
      step(1);
    end
    check("t2_no_press_in_bounce", n_press[1], 0);
    step(1);
    check("t2_no_press_e11", n_press[1], 0);
    step(1);
    check("t2_press", key_press, 3'b010);
    check("t2_no_spurious_rel", n_rel[1], 0);
    key_n = 3'b111;
    step(7);
    check("t2_single_press", n_press[1], 1);
    check("t2_single_release", n_rel[1], 1);
    check("t2_level_off", key_level, 3'b000);
    // 3: long hold on key 2
    clear_stats();
    key_n = 3'b011;
    step(40);
    check("t3_press_count", n_press[2], 1);
    check("t3_hold_count", n_hold[2], 1);
    check("t3_hold_latency", e_hold[2] - e_press[2], 10);
    key_n = 3'b111;
    step(8);
    check("t3_release_count", n_rel[2], 1);
    check("t3_level_off", key_level, 3'b000);
    // 4: keys 0 and 2 together
    clear_stats();
    key_n = 3'b010;
    step(6);
    check("t4_e6_press", key_press, 3'b000);
    step(1);
    check("t4_press_both", key_press, 3'b101);
    key_n = 3'b111;
    step(7);
    check("t4_release_both", key_release, 3'b101);
    check("t4_key1_quiet", n_press[1] + n_rel[1], 0);
    step(1);
    // 5: reset during PRESS_CHK with key 0 held
    clear_stats();
    key_n = 3'b110;
    step(4);
    rst = 1'b0;
    #1;
    check("t5_async_clear", {key_level, key_press, key_release, key_hold}, 12'h000);
    step(2);
    check("t5_no_press_in_reset", n_press[0], 0);
    rst = 1'b1;
    clear_stats();
    step(6);
    check("t5_e6_press", key_press, 3'b000);
    step(1);
    check("t5_e7_press", key_press, 3'b001);
    check("t5_press_count", n_press[0], 1);
    // 6: short release glitch while key 0 is PRESSED
    step(2);
    key_n[0] = 1'b1;
    step(2);
    key_n[0] = 1'b0;
    step(20);
    check("t6_no_release", n_rel[0], 0);
    check("t6_no_second_press", n_press[0], 1);
    check("t6_level_held", key_level, 3'b001);
    check("t6_hold_count", n_hold[0], 1);
    check("t6_hold_frozen", e_hold[0] - e_press[0], 12);
    rst = 1'b0;
    #1;
    check("rst_async_level", key_level, 3'b000);
    step(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
